// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment code constants and sampler state encoding for seg7_scan_capture
package seg7_pkg;

  // Active-low segment patterns, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational active-low 7-segment to BCD decoder
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       blank,
  output logic       err
);

  always_comb begin
    bcd   = 4'h0;
    blank = 1'b0;
    err   = 1'b0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: begin
        bcd   = BCD_BLANK;
        blank = 1'b1;
      end
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - recovers BCD frames from a scanned 7-segment bus
// Define SEG_ACTIVE_HIGH_EN for an active-high (common-cathode) seg/an bus.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] frame_bcd,
  output logic [NUM_DIGITS-1:0]   frame_blank,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    overrun
);

  localparam int                    CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE  = NUM_DIGITS'(1);

  logic [6:0]            seg_s1, seg_s2, seg_l;
  logic [NUM_DIGITS-1:0] an_s1, an_s2, an_l, sel;
  logic [NUM_DIGITS+6:0] pair, prev_pair;
  logic                  onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1    <= '1;
      seg_s2    <= '1;
      an_s1     <= '1;
      an_s2     <= '1;
      prev_pair <= '1;
    end else begin
      seg_s1    <= seg;
      seg_s2    <= seg_s1;
      an_s1     <= an;
      an_s2     <= an_s1;
      prev_pair <= pair;
    end
  end

`ifdef SEG_ACTIVE_HIGH_EN
  assign seg_l = ~seg_s2;
  assign an_l  = ~an_s2;
`else
  assign seg_l = seg_s2;
  assign an_l  = an_s2;
`endif

  assign pair   = {an_l, seg_l};
  assign sel    = ~an_l;
  assign onehot = (sel != '0) && ((sel & (sel - DIG_ONE)) == '0);

  logic [3:0] dec_bcd;
  logic       dec_blank, dec_err;

  seg7_to_bcd u_dec (
    .seg   (seg_l),
    .bcd   (dec_bcd),
    .blank (dec_blank),
    .err   (dec_err)
  );

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any change of the sampled pair restarts the run, so ghosting never captures.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (onehot) begin
          state_d = SETTLE;
          cnt_d   = CNT_ONE;
        end
      end
      SETTLE, HOLD: begin
        if (pair != prev_pair) begin
          state_d = onehot ? SETTLE : IDLE;
          cnt_d   = onehot ? CNT_ONE : '0;
        end else if (state_q == SETTLE) begin
          if (cnt_q == CNT_LAST) begin
            capture = 1'b1;
            state_d = HOLD;
          end
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic [4*NUM_DIGITS-1:0] dig_bcd, bcd_nxt;
  logic [NUM_DIGITS-1:0]   dig_blank, blank_nxt, dig_err, err_nxt, seen, seen_nxt;
  logic                    complete;

  always_comb begin
    bcd_nxt   = dig_bcd;
    blank_nxt = dig_blank;
    err_nxt   = dig_err;
    seen_nxt  = seen;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (capture && sel[i]) begin
        bcd_nxt[4*i +: 4] = dec_bcd;
        blank_nxt[i]      = dec_blank;
        err_nxt[i]        = dec_err;
        seen_nxt[i]       = 1'b1;
      end
    end
    complete = capture && (&seen_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_bcd   <= '0;
      dig_blank <= '0;
      dig_err   <= '0;
      seen      <= '0;
    end else begin
      dig_bcd   <= bcd_nxt;
      dig_blank <= blank_nxt;
      dig_err   <= err_nxt;
      seen      <= complete ? '0 : seen_nxt;
    end
  end

  // A frame completing against a stalled consumer is dropped, not queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_bcd   <= '0;
      frame_blank <= '0;
      frame_err   <= '0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (frame_valid && !frame_ready) begin
          overrun <= 1'b1;
        end else begin
          frame_valid <= 1'b1;
          frame_bcd   <= bcd_nxt;
          frame_blank <= blank_nxt;
          frame_err   <= err_nxt;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb/tb_seg7_scan_capture.sv - randomized model-checked bench for seg7_scan_capture
module tb_seg7_scan_capture;

  localparam int N = 4;
  localparam int S = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [6:0]   seg = 7'h7F;
  logic [N-1:0] an = 4'hF;
  logic         frame_ready = 1'b0;
  logic         frame_valid, overrun;
  logic [15:0]  frame_bcd;
  logic [3:0]   frame_blank, frame_err;

  always #5 clk = ~clk;

  seg7_scan_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .frame_bcd   (frame_bcd),
    .frame_blank (frame_blank),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  logic [6:0] codes [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: bus delayed by two samples, run length of identical pairs.
  logic [10:0] d1, d2, last;
  int          run;
  logic [15:0] m_dbcd, m_fbcd;
  logic [3:0]  m_dblank, m_derr, m_seen, m_fblank, m_ferr;
  logic        m_valid, m_ov;

  int          n_acc = 0;
  int          n_ov = 0;
  logic [15:0] acc_bcd;
  logic [3:0]  acc_blank, acc_err;

  task automatic model_reset();
    d1 = '1; d2 = '1; last = '1; run = 1;
    m_dbcd = '0; m_dblank = '0; m_derr = '0; m_seen = '0;
    m_fbcd = '0; m_fblank = '0; m_ferr = '0; m_valid = 1'b0; m_ov = 1'b0;
  endtask

  task automatic model_decode(input logic [6:0] s, output logic [3:0] b, output logic bl,
                              output logic er);
    b = 4'h0; bl = 1'b0; er = 1'b1;
    if (s == 7'h7F) begin
      b = 4'hF; bl = 1'b1; er = 1'b0;
    end else begin
      for (int i = 0; i < 10; i++)
        if (codes[i] == s) begin
          b = 4'(i); er = 1'b0;
        end
    end
  endtask

  task automatic model_step();
    logic [10:0] samp;
    logic [3:0]  selm, b;
    logic        bl, er, old_v, cap;
    samp = d2; d2 = d1; d1 = {an, seg};
    if (samp == last) run++;
    else run = 1;
    last = samp;
    selm = ~samp[10:7];
    cap = ($countones(selm) == 1) && (run == S);
    old_v = m_valid;
    m_ov = 1'b0;
    if (cap) begin
      model_decode(samp[6:0], b, bl, er);
      for (int k = 0; k < N; k++)
        if (selm[k]) begin
          m_dbcd[4*k +: 4] = b; m_dblank[k] = bl; m_derr[k] = er; m_seen[k] = 1'b1;
        end
    end
    if (cap && m_seen == 4'hF) begin
      m_seen = '0;
      if (old_v && !frame_ready) m_ov = 1'b1;
      else begin
        m_valid = 1'b1; m_fbcd = m_dbcd; m_fblank = m_dblank; m_ferr = m_derr;
      end
    end else if (old_v && frame_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("frame_valid", frame_valid, m_valid);
    chk("overrun", overrun, m_ov);
    if (m_valid) begin
      chk("frame_bcd", frame_bcd, m_fbcd);
      chk("frame_blank", frame_blank, m_fblank);
      chk("frame_err", frame_err, m_ferr);
    end
    if (frame_valid && frame_ready) begin
      n_acc++; acc_bcd = frame_bcd; acc_blank = frame_blank; acc_err = frame_err;
    end
    if (overrun) n_ov++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        compare_all();
      end else begin
        compare_all();
        model_step();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a; seg = s;
    tick(n);
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] s3);
    hold(4'b1110, s0, 10);
    hold(4'b1101, s1, 10);
    hold(4'b1011, s2, 10);
    hold(4'b0111, s3, 10);
    hold(4'hF, 7'h7F, 6);
  endtask

  initial begin
    int a0, o0, len;
    logic [31:0] r;

    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      hold(r[3:0], r[10:4], 1);
    end
    chk("rst_valid", frame_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_bcd", frame_bcd, 16'h0000);
    hold(4'hF, 7'h7F, 1);
    rst_n = 1'b1;
    tick(4);

    frame_ready = 1'b1;
    a0 = n_acc;
    scan4(codes[4], codes[3], codes[2], codes[1]);
    chk("normal_frames", n_acc - a0, 1);
    chk("normal_bcd", acc_bcd, 16'h1234);
    chk("normal_blank", acc_blank, 4'h0);
    chk("normal_err", acc_err, 4'h0);

    a0 = n_acc;
    hold(4'b1101, codes[5], 10);
    hold(4'b1011, codes[6], 10);
    hold(4'b0111, codes[7], 10);
    hold(4'b1110, codes[8], 5);
    hold(4'hF, 7'h7F, 10);
    hold(4'b1100, codes[8], 20);
    hold(4'hF, 7'h7F, 6);
    chk("ghost_frames", n_acc - a0, 0);
    hold(4'b1110, codes[9], 10);
    hold(4'hF, 7'h7F, 6);
    chk("ghost_then_frames", n_acc - a0, 1);
    chk("ghost_then_bcd", acc_bcd, 16'h7659);

    scan4(codes[9], codes[5], 7'b1111110, 7'b1111111);
    chk("codes_bcd", acc_bcd, 16'hF059);
    chk("codes_top", acc_bcd[15:8], 8'hF0);
    chk("codes_err", acc_err, 4'b0100);
    chk("codes_blank", acc_blank, 4'b1000);

    frame_ready = 1'b0;
    a0 = n_acc; o0 = n_ov;
    scan4(codes[1], codes[2], codes[3], codes[4]);
    chk("bp_valid", frame_valid, 1'b1);
    chk("bp_first_bcd", frame_bcd, 16'h4321);
    scan4(codes[5], codes[6], codes[7], codes[8]);
    chk("bp_overruns", n_ov - o0, 1);
    chk("bp_held_bcd", frame_bcd, 16'h4321);
    chk("bp_held_valid", frame_valid, 1'b1);
    frame_ready = 1'b1;
    tick(1);
    chk("bp_drop_valid", frame_valid, 1'b0);
    chk("bp_accepted", n_acc - a0, 1);
    chk("bp_accepted_bcd", acc_bcd, 16'h4321);

    a0 = n_acc;
    hold(4'b1110, codes[5], 10);
    hold(4'b1101, codes[6], 10);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", frame_valid, 1'b0);
    chk("midrst_bcd", frame_bcd, 16'h0000);
    hold(4'hF, 7'h7F, 2);
    rst_n = 1'b1;
    tick(3);
    scan4(codes[7], codes[8], codes[9], codes[0]);
    chk("midrst_frames", n_acc - a0, 1);
    chk("midrst_bcd_after", acc_bcd, 16'h0987);

    for (int p = 0; p < 400; p++) begin
      r = $urandom;
      if (r[3:0] < 11) an = ~(4'b0001 << r[5:4]);
      else if (r[3:0] < 13) an = 4'hF;
      else an = r[9:6];
      r = $urandom;
      if (r[3:0] < 10) seg = codes[r[7:4] % 10];
      else if (r[3:0] < 12) seg = 7'h7F;
      else seg = r[14:8];
      len = $urandom_range(12, 1);
      for (int c = 0; c < len; c++) begin
        r = $urandom;
        frame_ready = (r[1:0] != 2'b00);
        tick(1);
      end
    end
    hold(4'hF, 7'h7F, 12);
    frame_ready = 1'b1;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
